seconds_units_stage: RTL and testbench

Least-significant stage of the mm:ss countdown timer: a BCD mod-10 down-counter for the seconds-units digit with its own 1 Hz tick prescaler and run/pause/done control. It sits directly upstream of the mod-6 seconds-tens counter. Its `tc` pulse is the enable that makes the tens stage decrement, and it reads back whether all higher digits are zero so it can declare end-of-count.

---
 rtl/seconds_units_stage.sv | 88 ++++++++
 tb/tb_seconds_units_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/seconds_units_stage.sv
// seconds_units_stage: BCD mod-10 seconds-units down-counter with 1 Hz prescaler and run/pause/done control
module seconds_units_stage #(
  parameter int TICK_DIV = 100
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       loadn,
  input  logic [3:0] data,
  input  logic       start,
  input  logic       pause,
  input  logic       upper_zero,
  output logic [3:0] ones,
  output logic       tc,
  output logic       zero,
  output logic       running,
  output logic       done
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0] ones_q, ones_d;
  logic tc_q, tc_d, done_q, done_d, running_q, running_d;
  logic tick;
  assign tick = pre_q == PW'(TICK_DIV - 1);
  // next state in priority order: load > pause > start > tick
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    ones_d = ones_q;
    tc_d = 1'b0;
    done_d = 1'b0;
    if (!loadn && state_q != RUN) begin
      ones_d = (data > 4'd9) ? 4'd9 : data;
      pre_d = '0;
      state_d = IDLE;
    end else if (pause && state_q == RUN) begin
      state_d = PAUSE;
    end else if (start && state_q == IDLE) begin
      if (!(ones_q == 4'd0 && upper_zero)) begin
        state_d = RUN;
        pre_d = '0;
      end
    end else if (start && state_q == PAUSE) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (ones_q > 4'd1) begin
          ones_d = ones_q - 4'd1;
        end else if (ones_q == 4'd1) begin
          ones_d = 4'd0;
          state_d = upper_zero ? DONE : RUN;
          done_d = upper_zero;
        end else begin
          ones_d = upper_zero ? 4'd0 : 4'd9;
          tc_d = !upper_zero;
          state_d = upper_zero ? DONE : RUN;
          done_d = upper_zero;
        end
      end
    end
    running_d = state_d == RUN;
  end
  // state and registered outputs with synchronous clear
  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= IDLE;
      pre_q <= '0;
      ones_q <= 4'd0;
      tc_q <= 1'b0;
      done_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      ones_q <= ones_d;
      tc_q <= tc_d;
      done_q <= done_d;
      running_q <= running_d;
    end
  end
  assign ones = ones_q;
  assign tc = tc_q;
  assign done = done_q;
  assign running = running_q;
  assign zero = ones_q == 4'd0;
endmodule

// File: tb/tb_seconds_units_stage.sv
// tb_seconds_units_stage: directed self-checking bench for seconds_units_stage at TICK_DIV=4
module tb_seconds_units_stage;
  logic clock = 1'b0;
  logic clr = 1'b0, loadn = 1'b1, start = 1'b0, pause = 1'b0, upper_zero = 1'b0;
  logic [3:0] data = 4'd0;
  logic [3:0] ones;
  logic tc, zero, running, done;
  int checks = 0, failures = 0;
  seconds_units_stage #(.TICK_DIV(4)) dut (
    .clock(clock), .clr(clr), .loadn(loadn), .data(data), .start(start),
    .pause(pause), .upper_zero(upper_zero), .ones(ones), .tc(tc),
    .zero(zero), .running(running), .done(done)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  initial begin
    int n;
    #1;
    clr = 1; loadn = 0; data = 4'd7;
    step();
    chk("rst_ones", ones, 0); chk("rst_zero", zero, 1); chk("rst_tc", tc, 0);
    chk("rst_done", done, 0); chk("rst_run", running, 0);
    clr = 0; loadn = 1;
    upper_zero = 1; loadn = 0; data = 4'd3;
    step();
    loadn = 1;
    chk("load3", ones, 3);
    start = 1;
    step();
    start = 0;
    chk("start_run", running, 1);
    for (int d = 2; d >= 0; d--) begin
      repeat (3) step();
      chk("hold_digit", ones, d + 1);
      step();
      chk("dec_digit", ones, d);
      chk("done_timing", done, d == 0 ? 1 : 0);
    end
    chk("done_run", running, 0); chk("done_zero", zero, 1);
    step();
    chk("done_pulse", done, 0); chk("done_hold", ones, 0); chk("done_run2", running, 0);
    start = 1;
    step();
    start = 0;
    chk("done_ign_start", running, 0);
    upper_zero = 0; loadn = 0; data = 4'd0;
    step();
    loadn = 1;
    start = 1;
    step();
    start = 0;
    repeat (3) step();
    chk("pre_borrow_tc", tc, 0); chk("pre_borrow_ones", ones, 0);
    step();
    chk("borrow_ones", ones, 9); chk("borrow_tc", tc, 1);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) chk("tc_one_cycle", tc, 0);
    end while (!tc && n < 60);
    chk("tc_period", n, 40);
    chk("tc2_ones", ones, 9);
    loadn = 0; data = 4'd2;
    step();
    loadn = 1;
    chk("load_in_run", ones, 9); chk("load_in_run_r", running, 1);
    start = 1; pause = 1;
    step();
    start = 0; pause = 0;
    chk("start_pause", running, 0);
    loadn = 0; data = 4'd12;
    step();
    loadn = 1;
    chk("clamp", ones, 9);
    clr = 1;
    step();
    clr = 0;
    upper_zero = 1; loadn = 0; data = 4'd5;
    step();
    loadn = 1;
    start = 1;
    step();
    start = 0;
    repeat (2) step();
    pause = 1;
    repeat (10) step();
    pause = 0;
    chk("pause_run", running, 0); chk("pause_ones", ones, 5);
    start = 1;
    step();
    start = 0;
    chk("resume_run", running, 1);
    step();
    chk("resume_hold", ones, 5);
    step();
    chk("resume_dec", ones, 4);
    clr = 1;
    step();
    clr = 0;
    upper_zero = 1; start = 1;
    step();
    start = 0;
    chk("allzero_run", running, 0); chk("allzero_done", done, 0);
    step();
    chk("allzero_done2", done, 0);
    upper_zero = 0; start = 1;
    step();
    start = 0;
    repeat (3) step();
    clr = 1;
    step();
    clr = 0;
    chk("clr_tc", tc, 0); chk("clr_ones", ones, 0); chk("clr_run", running, 0);
    step();
    chk("clr_tc2", tc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
